rsa_modexp: RTL and testbench

Parametrised modular-exponentiation engine computing R = M^E mod N on WIDTH-bit operands. It replaces the fixed 256-bit RSA core with a generic width and a complete start/ready/done handshake. It also adds base pre-reduction, early termination on the exponent's leading zeros, and error reporting. It keeps the byte-addressed register interface used by the host-side bus adapter.

---
 rtl/rsa_pkg.sv | 32 +++
 rtl/rsa_modmul.sv | 66 ++++++
 rtl/rsa_modexp.sv | 198 +++++++++++++++++++
 tb/tb_rsa_modexp.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the modular-exponentiation engine: FSM states,
// register-select codes and the request bundle sent to the shared multiplier.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REDUCE,
    STEP,
    MUL,
    SQR,
    DONE
  } state_e;

  localparam logic [1:0] SEL_R = 2'd0;
  localparam logic [1:0] SEL_M = 2'd1;
  localparam logic [1:0] SEL_E = 2'd2;
  localparam logic [1:0] SEL_N = 2'd3;

  // Which operand pair the single multiplier is working on.
  typedef enum logic [1:0] {
    OP_RED,
    OP_MUL,
    OP_SQR
  } mm_op_e;

  typedef struct packed {
    logic   start;
    mm_op_e op;
  } mm_req_t;

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved left-to-right shift-add modular multiplier: p = a*b mod n.
// One load cycle on start, then WIDTH bit cycles; done marks the last bit cycle.
module rsa_modmul #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH+1:0] acc0, acc1, acc2;

  // a and n are used live, so the caller holds them stable while busy.
  always_comb begin
    acc0 = {1'b0, p_q, 1'b0} + (b_q[WIDTH-1] ? {2'b00, a} : '0);
    acc1 = (acc0 >= {2'b00, n}) ? acc0 - {2'b00, n} : acc0;
    acc2 = (acc1 >= {2'b00, n}) ? acc1 - {2'b00, n} : acc1;

    busy_d = busy_q;
    cnt_d  = cnt_q;
    b_d    = b_q;
    p_d    = p_q;
    done   = busy_q && (cnt_q == '0);

    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(WIDTH - 1);
      b_d    = b;
      p_d    = '0;
    end else if (busy_q) begin
      p_d   = acc2[WIDTH-1:0];
      b_d   = b_q << 1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) busy_d = 1'b0;
    end
  end

  // The final product is presented combinationally during the done cycle.
  assign p = acc2[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      b_q    <= '0;
      p_q    <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      b_q    <= b_d;
      p_q    <= p_d;
    end
  end

endmodule

// File: rtl/rsa_modexp.sv
// Modular exponentiation R = M^E mod N with a byte-addressed register file,
// right-to-left square-and-multiply around one shared modular multiplier.
module rsa_modexp
  import rsa_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int AW    = $clog2(WIDTH / 8)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [1:0]    reg_sel,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    data_i,
  output logic [7:0]    data_o,
  input  logic          start,
  output logic          ready,
  output logic          done,
  output logic          err
);

  localparam int NB = WIDTH / 8;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d, e_q, e_d, n_q, n_d;
  logic [WIDTH-1:0] r_q, r_d, t_q, t_d, ec_q, ec_d;
  logic             shifted_q, shifted_d;
  logic             err_q, err_d;
  logic             mm_busy_q, mm_busy_d;
  logic [7:0]       data_o_q, data_o_d;

  mm_req_t          mm_req;
  logic [WIDTH-1:0] mm_a, mm_b, mm_p;
  logic             mm_done;

  logic             wr_ok;
  logic [WIDTH-1:0] rd_word;
  logic [7:0]       rd_byte [NB];

  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign err    = err_q;
  assign data_o = data_o_q;
  assign wr_ok  = we && ready;

  generate
    for (genvar k = 0; k < NB; k++) begin : g_byte
      logic hit;
      assign hit            = wr_ok && (addr == AW'(k));
      assign m_d[8*k +: 8]  = (hit && reg_sel == SEL_M) ? data_i : m_q[8*k +: 8];
      assign e_d[8*k +: 8]  = (hit && reg_sel == SEL_E) ? data_i : e_q[8*k +: 8];
      assign n_d[8*k +: 8]  = (hit && reg_sel == SEL_N) ? data_i : n_q[8*k +: 8];
      assign rd_byte[k]     = rd_word[8*k +: 8];
    end
  endgenerate

  always_comb begin
    rd_word = r_q;
    case (reg_sel)
      SEL_M:   rd_word = m_q;
      SEL_E:   rd_word = e_q;
      SEL_N:   rd_word = n_q;
      default: rd_word = r_q;
    endcase
    data_o_d = rd_byte[addr];
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a value held (latch inferred).
  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    t_d          = t_q;
    ec_d         = ec_q;
    shifted_d    = shifted_q;
    err_d        = err_q;
    mm_req.start = 1'b0;
    mm_req.op    = OP_RED;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = CHECK;
          err_d   = 1'b0;
        end
      end
      CHECK: begin
        if (n_q < WIDTH'(2)) begin
          r_d     = '0;
          err_d   = (n_q == '0);
          state_d = DONE;
        end else begin
          ec_d    = e_q;
          r_d     = WIDTH'(1);
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        mm_req.op    = OP_RED;
        mm_req.start = !mm_busy_q;
        if (mm_done) begin
          t_d     = mm_p;
          state_d = (ec_q == '0) ? DONE : STEP;
        end
      end
      // STEP doubles as the load cycle of the multiplication it selects.
      STEP: begin
        mm_req.op    = ec_q[0] ? OP_MUL : OP_SQR;
        mm_req.start = 1'b1;
        shifted_d    = 1'b0;
        state_d      = ec_q[0] ? MUL : SQR;
      end
      MUL: begin
        mm_req.op    = OP_MUL;
        mm_req.start = !mm_busy_q;
        if (mm_done) begin
          r_d       = mm_p;
          ec_d      = ec_q >> 1;
          shifted_d = 1'b1;
          state_d   = (ec_q[WIDTH-1:1] == '0) ? DONE : SQR;
        end
      end
      SQR: begin
        mm_req.op    = OP_SQR;
        mm_req.start = !mm_busy_q;
        if (mm_done) begin
          t_d = mm_p;
          if (!shifted_q) ec_d = ec_q >> 1;
          state_d = STEP;
        end
      end
      default: state_d = IDLE;
    endcase

    mm_busy_d = mm_req.start ? 1'b1 : (mm_done ? 1'b0 : mm_busy_q);
  end

  always_comb begin
    mm_a = t_q;
    mm_b = t_q;
    case (mm_req.op)
      OP_RED: begin
        mm_a = WIDTH'(1);
        mm_b = m_q;
      end
      OP_MUL: begin
        mm_a = r_q;
        mm_b = t_q;
      end
      default: ;
    endcase
  end

  rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk   (clk),
    .reset (reset),
    .start (mm_req.start),
    .a     (mm_a),
    .b     (mm_b),
    .n     (n_q),
    .p     (mm_p),
    .done  (mm_done)
  );

  // NOTE: state flops take non-blocking assignments so all registers update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      // NOTE: the operand registers are cleared as well, so an aborted run
      // leaves no stale M, E or N behind for the next one.
      m_q       <= '0;
      e_q       <= '0;
      n_q       <= '0;
      r_q       <= '0;
      t_q       <= '0;
      ec_q      <= '0;
      shifted_q <= 1'b0;
      err_q     <= 1'b0;
      mm_busy_q <= 1'b0;
      data_o_q  <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      e_q       <= e_d;
      n_q       <= n_d;
      r_q       <= r_d;
      t_q       <= t_d;
      ec_q      <= ec_d;
      shifted_q <= shifted_d;
      err_q     <= err_d;
      mm_busy_q <= mm_busy_d;
      data_o_q  <= data_o_d;
    end
  end

endmodule

// File: tb/tb_rsa_modexp.sv
// Self-checking bench for rsa_modexp at WIDTH=16 and WIDTH=256 against a
// square-and-multiply reference using wide integer arithmetic.
module tb_rsa_modexp;
  import rsa_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       we1, start1, ready1, done1, err1;
  logic [1:0] sel1;
  logic [0:0] addr1;
  logic [7:0] di1, do1;

  logic       we2, start2, ready2, done2, err2;
  logic [1:0] sel2;
  logic [4:0] addr2;
  logic [7:0] di2, do2;

  rsa_modexp #(.WIDTH(16)) u_w16 (
    .clk(clk), .reset(rst_n), .we(we1), .reg_sel(sel1), .addr(addr1),
    .data_i(di1), .data_o(do1), .start(start1), .ready(ready1),
    .done(done1), .err(err1)
  );

  rsa_modexp #(.WIDTH(256)) u_w256 (
    .clk(clk), .reset(rst_n), .we(we2), .reg_sel(sel2), .addr(addr2),
    .data_i(di2), .data_o(do2), .start(start2), .ready(ready2),
    .done(done2), .err(err2)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Expectations for the run in flight, consumed by the compare process.
  bit         active = 1'b0;
  bit         post   = 1'b0;
  bit         which  = 1'b0;
  int         cyc    = 0;
  int         exp_edge = 0;
  bit         exp_err  = 1'b0;
  logic [255:0] exp_r  = '0;

  logic cur_done, cur_ready, cur_err;
  assign cur_done  = which ? done2  : done1;
  assign cur_ready = which ? ready2 : ready1;
  assign cur_err   = which ? err2   : err1;

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] modexp(input logic [255:0] m, input logic [255:0] e,
                                          input logic [255:0] n);
    logic [511:0] acc, base, nn;
    if (n < 256'd2) return '0;
    nn   = {256'b0, n};
    base = {256'b0, m} % nn;
    acc  = 512'd1;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) acc = (acc * base) % nn;
      base = (base * base) % nn;
    end
    return acc[255:0];
  endfunction

  function automatic int edge_of(input int w, input logic [255:0] e, input logic [255:0] n);
    int pop, l;
    pop = 0;
    l   = 0;
    if (n < 256'd2) return 2;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) begin
        pop++;
        l = i + 1;
      end
    end
    return 2 + (1 + pop + ((l > 0) ? l - 1 : 0)) * (w + 1);
  endfunction

  // Compare process: counts edges after the accepted start and checks the
  // handshake outputs against the model's expected completion edge.
  initial begin
    forever begin
      @(negedge clk);
      if (post) begin
        check_int("done_one_cycle", int'(cur_done), 0);
        post = 1'b0;
      end
      if (active) begin
        cyc++;
        if (cyc == 1) begin
          check_int("ready_low_after_start", int'(cur_ready), 0);
          check_int("err_cleared_by_start", int'(cur_err), 0);
        end
        if (cur_done) begin
          check_int("done_edge", cyc, exp_edge);
          check_int("ready_at_done", int'(cur_ready), 1);
          check_int("err_at_done", int'(cur_err), int'(exp_err));
          active = 1'b0;
          post   = 1'b1;
        end
      end
    end
  end

  task automatic write_reg(input bit w, input logic [1:0] sel, input logic [255:0] v);
    int nb;
    nb = w ? 32 : 2;
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      if (w) begin
        we2 = 1'b1; sel2 = sel; addr2 = 5'(k); di2 = v[8*k +: 8];
      end else begin
        we1 = 1'b1; sel1 = sel; addr1 = 1'(k); di1 = v[8*k +: 8];
      end
    end
    @(negedge clk);
    we1 = 1'b0;
    we2 = 1'b0;
  endtask

  task automatic read_reg(input bit w, input logic [1:0] sel, output logic [255:0] v);
    int nb;
    nb = w ? 32 : 2;
    v  = '0;
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      if (w) begin
        sel2 = sel; addr2 = 5'(k);
      end else begin
        sel1 = sel; addr1 = 1'(k);
      end
      @(negedge clk);
      v[8*k +: 8] = w ? do2 : do1;
    end
  endtask

  task automatic begin_run(input bit w, input logic [255:0] m, input logic [255:0] e,
                           input logic [255:0] n);
    write_reg(w, SEL_M, m);
    write_reg(w, SEL_E, e);
    write_reg(w, SEL_N, n);
    exp_r = modexp(m, e, n);
    @(negedge clk);
    if (w) start2 = 1'b1;
    else   start1 = 1'b1;
    @(posedge clk);
    which    = w;
    cyc      = 0;
    exp_edge = edge_of(w ? 256 : 16, e, n);
    exp_err  = (n == '0);
    active   = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic finish_run(input bit w, output logic [255:0] r);
    int budget;
    budget = exp_edge + 10;
    for (int i = 0; i < budget && active; i++) @(negedge clk);
    if (active) begin
      check_int("done_within_budget", 0, 1);
      active = 1'b0;
    end
    @(negedge clk);
    read_reg(w, SEL_R, r);
    check_wide("result_R", r, exp_r);
  endtask

  initial begin
    logic [255:0] v, r, m, e, n;

    rst_n = 1'b0;
    {we1, start1, sel1, addr1, di1} = '0;
    {we2, start2, sel2, addr2, di2} = '0;
    repeat (3) @(negedge clk);

    check_int("rst_ready", int'(ready1), 1);
    check_int("rst_done", int'(done1), 0);
    check_int("rst_err", int'(err1), 0);
    check_int("rst_data_o", int'(do1), 0);
    check_int("rst_ready_w256", int'(ready2), 1);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      read_reg(1'b0, 2'(s), v);
      check_wide("rst_reg_zero", v, '0);
    end

    // Pin the reference model to hand-computed values.
    check_wide("model_4_13_497", modexp(256'd4, 256'd13, 256'd497), 256'd445);
    check_wide("model_1000_1_497", modexp(256'd1000, 256'd1, 256'd497), 256'd6);
    check_int("model_edge_e13", edge_of(16, 256'd13, 256'd497), 121);
    check_int("model_edge_e0", edge_of(16, 256'd0, 256'd7), 19);

    begin_run(1'b0, 256'd4, 256'd13, 256'd497);
    finish_run(1'b0, r);
    check_int("R_byte0", int'(r[7:0]), 8'hBD);
    check_int("R_byte1", int'(r[15:8]), 8'h01);
    read_reg(1'b0, SEL_M, v);
    check_wide("M_unchanged", v, 256'd4);
    read_reg(1'b0, SEL_E, v);
    check_wide("E_unchanged", v, 256'd13);

    begin_run(1'b0, 256'd1000, 256'd1, 256'd497);
    finish_run(1'b0, r);
    begin_run(1'b0, 256'd3, 256'd0, 256'd7);
    finish_run(1'b0, r);

    // N == 0 flags err; N == 1 does not; the next valid run clears it.
    begin_run(1'b0, 256'h1234, 256'd5, 256'd0);
    finish_run(1'b0, r);
    check_int("err_held_after_done", int'(err1), 1);
    begin_run(1'b0, 256'd3, 256'd5, 256'd7);
    finish_run(1'b0, r);
    begin_run(1'b0, 256'd9, 256'd3, 256'd1);
    finish_run(1'b0, r);

    // Writes and start while busy are ignored.
    begin_run(1'b0, 256'd4, 256'd13, 256'd497);
    repeat (5) @(negedge clk);
    start1 = 1'b1;
    write_reg(1'b0, SEL_M, 256'hFFFF);
    start1 = 1'b0;
    finish_run(1'b0, r);
    read_reg(1'b0, SEL_M, v);
    check_wide("M_write_while_busy_ignored", v, 256'd4);

    // Reset mid-run aborts and clears everything.
    begin_run(1'b0, 256'd4, 256'd13, 256'd497);
    repeat (39) @(negedge clk);
    rst_n  = 1'b0;
    active = 1'b0;
    post   = 1'b0;
    #1;
    check_int("abort_ready", int'(ready1), 1);
    check_int("abort_done", int'(done1), 0);
    check_int("abort_err", int'(err1), 0);
    check_int("abort_data_o", int'(do1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      read_reg(1'b0, 2'(s), v);
      check_wide("abort_reg_zero", v, '0);
    end
    begin_run(1'b0, 256'd7, 256'd11, 256'd33);
    finish_run(1'b0, r);

    // Random 16-bit operands, including occasional N < 2.
    for (int i = 0; i < 20; i++) begin
      m = 256'($urandom_range(0, 65535));
      e = 256'($urandom_range(0, 65535));
      n = (i % 7 == 3) ? 256'($urandom_range(0, 1)) : 256'($urandom_range(2, 65535));
      begin_run(1'b0, m, e, n);
      finish_run(1'b0, r);
    end

    // Random 256-bit operands: N odd with top bit set, M < N, short exponents.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        n[32*j +: 32] = $urandom();
        m[32*j +: 32] = $urandom();
      end
      n[255] = 1'b1;
      n[0]   = 1'b1;
      if (m >= n) m = m - n;
      e = 256'($urandom_range(1, 255));
      begin_run(1'b1, m, e, n);
      finish_run(1'b1, r);
      if (i == 0) begin
        read_reg(1'b1, SEL_N, v);
        check_wide("N_unchanged_w256", v, n);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_miss);
    $fatal(1, "watchdog expired");
  end

endmodule
